uno_hand_cursor: RTL and testbench
==================================

Name: uno_hand_cursor

Overview:
- Per-player turn controller for the UNO game.
- Moves a cursor over the player's hand, with one extra DRAW slot, driven by debounced key pulses.
- On select: validates the card, runs colour selection for wild cards, and issues one play/draw request over a valid/ready handshake to the game engine.
- Sits between the Debounce outputs and the Uno engine; o_index also feeds Display.i_index.

Parameters:
- MAX_HAND, 108, maximum cards held; legal card indices are 0..MAX_HAND-1.
- DRAW_SLOT, 108, cursor value denoting the draw pile; must be >= MAX_HAND.
- IDX_W, 7, width of index and hand count; must hold DRAW_SLOT.
- CARD_W, 6, card code width; [5:4] colour, [3:0] value; 4'b1101 and 4'b1110 are wild.
- TIMEOUT_CYCLES, 1000000, auto-draw timeout in clock cycles; used only with the optional feature.

Ports:
- i_clk  in  1  system clock (1 MHz domain).
- i_rst_n  in  1  asynchronous active-low reset.
- i_enable  in  1  level; high while it is this player's turn.
- i_left  in  1  one-cycle pulse; cursor/colour decrement.
- i_right  in  1  one-cycle pulse; cursor/colour increment.
- i_select  in  1  one-cycle pulse; confirm.
- i_hand_num  in  IDX_W  current number of cards in hand (0..MAX_HAND).
- i_card  in  CARD_W  card code at o_index, looked up combinationally upstream.
- i_playable  in  1  upstream legality of i_card against the last card.
- i_req_ready  in  1  engine accepts request.
- o_index  out  IDX_W  cursor position.
- o_select_color  out  1  high in colour-select state.
- o_color  out  2  colour being chosen or issued.
- o_req_valid  out  1  request pending.
- o_req_draw  out  1  request is a draw, not a play.
- o_req_card  out  CARD_W  card being played (0 on draw).
- o_reject  out  1  one-cycle pulse: illegal select ignored.
- o_busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: state IDLE; o_index=0, o_color=0; all req outputs, o_reject, o_select_color and o_busy = 0.
- All registers are updated on posedge i_clk. Every response appears one cycle after the triggering pulse.
- States: IDLE, NAV, COLOR, REQ, DONE.
- IDLE -> NAV when i_enable=1. On entry o_index = 0 if i_hand_num>0, else DRAW_SLOT.
- NAV, i_right (N = i_hand_num):
  - DRAW_SLOT -> 0; index N-1 -> DRAW_SLOT; otherwise +1.
  - If N=0 the index stays at DRAW_SLOT.
- NAV, i_left: 0 -> DRAW_SLOT; DRAW_SLOT -> N-1; otherwise -1. If N=0 the index stays at DRAW_SLOT.
- i_left and i_right in the same cycle: both ignored.
- Priority of simultaneous inputs: clamp > select > left/right.
- NAV clamp: if o_index >= N and o_index != DRAW_SLOT (hand shrank), next o_index = N-1, or DRAW_SLOT if N=0. Any key pulse in that cycle is ignored.
- NAV select:
  - index == DRAW_SLOT -> REQ with draw=1, card=0, color=0.
  - else !i_playable -> o_reject=1 for one cycle; stay in NAV.
  - else i_card[3:0] is wild -> latch the card; o_color=0; go to COLOR.
  - else latch the card; o_color = i_card[5:4]; go to REQ.
- COLOR:
  - o_select_color=1.
  - i_right: o_color+1 mod 4. i_left: o_color-1 mod 4.
  - i_select -> REQ with o_color as the chosen colour.
- i_enable=0 while in NAV or COLOR: abort to IDLE next cycle; no request issued.
- REQ:
  - o_req_valid=1; draw/card/color are held stable until i_req_ready=1 is sampled.
  - Handshake completes in that cycle; the next cycle is DONE with o_req_valid=0.
  - The request is never withdrawn. i_enable=0 and key pulses are ignored in REQ.
- DONE: wait until i_enable=0, then IDLE. This guarantees one request per turn.
- Arithmetic is unsigned, IDX_W bits; wrap rules above replace natural overflow.

Optional Feature:
- Macro: UNO_CURSOR_TIMEOUT_EN.
- With the macro defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) runs in NAV and COLOR.
  - It clears on entering NAV and on any i_left/i_right/i_select pulse.
  - When it reaches TIMEOUT_CYCLES-1:
    - In NAV: go to REQ with draw=1.
    - In COLOR: go to REQ with the current o_color.
- Without the macro: no counter and no timeout; a state waits indefinitely.

Test Plan:
- Reset, then enable with i_hand_num=10: o_index=0. Ten i_right pulses give 1..9, then 108. An 11th pulse gives 0. i_left from 0 gives 108, then 9.
- i_hand_num=0, enable: o_index=108. Left and right hold at 108. Select gives o_req_valid=1, o_req_draw=1, o_req_card=0.
- Cursor at 3, i_card=6'b100101, i_playable=1, select: REQ with card 0x25, color=2'b10. Hold i_req_ready=0 for 5 cycles: payload stable. Ready=1 gives valid=0 next cycle, and DONE until i_enable=0.
- Cursor on i_card=6'b001110, select: o_select_color=1, o_color=0. Left gives 3, right twice gives 1. Select gives REQ with card 0x0E, color=1.
- i_playable=0, select: o_reject high exactly one cycle; state stays NAV; no request.
- Cursor at 9, i_hand_num drops to 5 while i_right pulses: o_index=4, pulse ignored. Under UNO_CURSOR_TIMEOUT_EN with TIMEOUT_CYCLES=16: idle NAV issues a draw request after 16 cycles.

Source files
------------

// File: rtl/uno_hand_cursor.sv
// Per-player UNO turn controller: hand cursor with DRAW slot, wild colour pick, one play/draw request per turn.
// Latency: every response is registered one cycle after its key pulse. The request holds until i_req_ready. Optional auto-draw: UNO_CURSOR_TIMEOUT_EN.
module uno_hand_cursor #(
  parameter int MAX_HAND       = 108,
  parameter int DRAW_SLOT      = 108,
  parameter int IDX_W          = 7,
  parameter int CARD_W         = 6,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_enable,
  input  logic              i_left,
  input  logic              i_right,
  input  logic              i_select,
  input  logic [IDX_W-1:0]  i_hand_num,
  input  logic [CARD_W-1:0] i_card,
  input  logic              i_playable,
  input  logic              i_req_ready,
  output logic [IDX_W-1:0]  o_index,
  output logic              o_select_color,
  output logic [1:0]        o_color,
  output logic              o_req_valid,
  output logic              o_req_draw,
  output logic [CARD_W-1:0] o_req_card,
  output logic              o_reject,
  output logic              o_busy
);

  typedef enum logic [2:0] {S_IDLE, S_NAV, S_COLOR, S_REQ, S_DONE} state_t;

  localparam logic [IDX_W-1:0] DRAW_IDX = IDX_W'(DRAW_SLOT);

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  index_q, index_d;
  logic [1:0]        color_q, color_d;
  logic [CARD_W-1:0] card_q, card_d;
  logic              draw_q, draw_d;
  logic              reject_q, reject_d;

  logic [IDX_W-1:0]  last_idx;
  logic              hand_empty;
  logic              clamp_hit;
  logic              is_wild;
  logic              go_right;
  logic              go_left;
  logic              key_any;
  logic              timeout_hit;

  assign hand_empty = (i_hand_num == '0);
  assign last_idx   = i_hand_num - IDX_W'(1);
  // Hand shrank under the cursor; the DRAW slot is always legal.
  assign clamp_hit  = (index_q >= i_hand_num) && (index_q != DRAW_IDX);
  assign is_wild    = (i_card[3:0] == 4'b1101) || (i_card[3:0] == 4'b1110);
  assign go_right   = i_right && !i_left;
  assign go_left    = i_left && !i_right;
  assign key_any    = i_left || i_right || i_select;

`ifdef UNO_CURSOR_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      to_cnt_q <= '0;
    end else if ((state_q != S_NAV && state_q != S_COLOR) || key_any) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_q + TO_W'(1);
    end
  end

  assign timeout_hit = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) && !key_any;
`else
  assign timeout_hit = 1'b0;
`endif

  // State and datapath registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      index_q  <= '0;
      color_q  <= '0;
      card_q   <= '0;
      draw_q   <= 1'b0;
      reject_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      index_q  <= index_d;
      color_q  <= color_d;
      card_q   <= card_d;
      draw_q   <= draw_d;
      reject_q <= reject_d;
    end
  end

  // Next-state and next-datapath logic.
  always_comb begin
    state_d  = state_q;
    index_d  = index_q;
    color_d  = color_q;
    card_d   = card_q;
    draw_d   = draw_q;
    reject_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_enable) begin
          state_d = S_NAV;
          index_d = hand_empty ? DRAW_IDX : '0;
        end
      end
      S_NAV: begin
        if (!i_enable) begin
          state_d = S_IDLE;
        end else if (clamp_hit) begin
          index_d = hand_empty ? DRAW_IDX : last_idx;
        end else if (i_select) begin
          if (index_q == DRAW_IDX) begin
            state_d = S_REQ;
            draw_d  = 1'b1;
            card_d  = '0;
            color_d = '0;
          end else if (!i_playable) begin
            reject_d = 1'b1;
          end else begin
            draw_d  = 1'b0;
            card_d  = i_card;
            state_d = is_wild ? S_COLOR : S_REQ;
            color_d = is_wild ? 2'b00 : i_card[5:4];
          end
        end else if (timeout_hit) begin
          state_d = S_REQ;
          draw_d  = 1'b1;
          card_d  = '0;
          color_d = '0;
        end else if (go_right) begin
          if (hand_empty || index_q == last_idx) index_d = DRAW_IDX;
          else if (index_q == DRAW_IDX)          index_d = '0;
          else                                   index_d = index_q + IDX_W'(1);
        end else if (go_left) begin
          if (hand_empty)                index_d = DRAW_IDX;
          else if (index_q == DRAW_IDX)  index_d = last_idx;
          else if (index_q == '0)        index_d = DRAW_IDX;
          else                           index_d = index_q - IDX_W'(1);
        end
      end
      S_COLOR: begin
        if (!i_enable)              state_d = S_IDLE;
        else if (i_select)          state_d = S_REQ;
        else if (timeout_hit)       state_d = S_REQ;
        else if (go_right)          color_d = color_q + 2'd1;
        else if (go_left)           color_d = color_q - 2'd1;
      end
      S_REQ: begin
        if (i_req_ready) state_d = S_DONE;
      end
      S_DONE: begin
        if (!i_enable) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs.
  always_comb begin
    o_index        = index_q;
    o_color        = color_q;
    o_req_draw     = draw_q;
    o_req_card     = card_q;
    o_reject       = reject_q;
    o_req_valid    = (state_q == S_REQ);
    o_select_color = (state_q == S_COLOR);
    o_busy         = (state_q != S_IDLE);
  end

endmodule

// File: tb/tb_uno_hand_cursor.sv
// Self-checking bench for uno_hand_cursor: inline checks per scenario plus a request scoreboard.
`timescale 1ns/1ps
module tb_uno_hand_cursor;

  typedef struct packed {
    logic       draw;
    logic [5:0] card;
    logic [1:0] color;
  } req_t;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_enable = 1'b0;
  logic       i_left = 1'b0;
  logic       i_right = 1'b0;
  logic       i_select = 1'b0;
  logic [6:0] i_hand_num = 7'd0;
  logic [5:0] i_card = 6'd0;
  logic       i_playable = 1'b0;
  logic       i_req_ready = 1'b0;
  logic [6:0] o_index;
  logic       o_select_color;
  logic [1:0] o_color;
  logic       o_req_valid;
  logic       o_req_draw;
  logic [5:0] o_req_card;
  logic       o_reject;
  logic       o_busy;

  int   n_checks = 0;
  int   n_fail = 0;
  req_t exp_q[$];

  uno_hand_cursor #(.TIMEOUT_CYCLES(16)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_enable(i_enable),
    .i_left(i_left), .i_right(i_right), .i_select(i_select),
    .i_hand_num(i_hand_num), .i_card(i_card), .i_playable(i_playable),
    .i_req_ready(i_req_ready), .o_index(o_index), .o_select_color(o_select_color),
    .o_color(o_color), .o_req_valid(o_req_valid), .o_req_draw(o_req_draw),
    .o_req_card(o_req_card), .o_reject(o_reject), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Scoreboard: a handshake completes at the next posedge; inputs are stable at negedge.
  always @(negedge i_clk) begin
    if (i_rst_n && o_req_valid && i_req_ready) begin
      req_t got, exp;
      got = '{o_req_draw, o_req_card, o_req_color_w()};
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got draw=%0b card=%h color=%0d, required no request", got.draw, got.card, got.color);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          n_fail++;
          $display("FAIL sb_payload: got draw=%0b card=%h color=%0d, required draw=%0b card=%h color=%0d",
                   got.draw, got.card, got.color, exp.draw, exp.card, exp.color);
        end
      end
    end
  end

  function automatic logic [1:0] o_req_color_w();
    return o_color;
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic press(input bit l, input bit r, input bit s);
    i_left = l; i_right = r; i_select = s;
    tick();
    i_left = 1'b0; i_right = 1'b0; i_select = 1'b0;
  endtask

  task automatic end_turn();
    i_enable = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    tick();
    n_checks++;
    if ({o_index, o_color, o_req_valid, o_req_draw, o_req_card, o_reject, o_select_color, o_busy} !== 20'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: idx=%0d color=%0d valid=%0b draw=%0b card=%h rej=%0b sel=%0b busy=%0b, required all 0",
               o_index, o_color, o_req_valid, o_req_draw, o_req_card, o_reject, o_select_color, o_busy);
    end
    i_rst_n = 1'b1;
    tick();
  endtask

  task automatic test_nav_wrap();
    int exp_idx;
    i_hand_num = 7'd10;
    i_enable = 1'b1;
    tick();
    n_checks++;
    if (o_index !== 7'd0 || o_busy !== 1'b1) begin
      n_fail++; $display("FAIL nav_entry: idx=%0d busy=%0b, required idx=0 busy=1", o_index, o_busy);
    end
    for (int i = 1; i <= 11; i++) begin
      press(0, 1, 0);
      exp_idx = (i == 10) ? 108 : (i == 11) ? 0 : i;
      n_checks++;
      if (o_index !== 7'(exp_idx)) begin
        n_fail++; $display("FAIL nav_right_%0d: idx=%0d, required %0d", i, o_index, exp_idx);
      end
    end
    press(1, 0, 0);
    n_checks++;
    if (o_index !== 7'd108) begin
      n_fail++; $display("FAIL nav_left_wrap: idx=%0d, required 108", o_index);
    end
    press(1, 0, 0);
    n_checks++;
    if (o_index !== 7'd9) begin
      n_fail++; $display("FAIL nav_left_draw: idx=%0d, required 9", o_index);
    end
    press(1, 1, 0);
    n_checks++;
    if (o_index !== 7'd9) begin
      n_fail++; $display("FAIL nav_both_keys: idx=%0d, required 9", o_index);
    end
    end_turn();
    n_checks++;
    if (o_busy !== 1'b0) begin
      n_fail++; $display("FAIL nav_abort: busy=%0b, required 0", o_busy);
    end
  endtask

  task automatic test_empty_hand();
    i_hand_num = 7'd0;
    i_enable = 1'b1;
    tick();
    n_checks++;
    if (o_index !== 7'd108) begin
      n_fail++; $display("FAIL empty_entry: idx=%0d, required 108", o_index);
    end
    press(1, 0, 0);
    press(0, 1, 0);
    n_checks++;
    if (o_index !== 7'd108) begin
      n_fail++; $display("FAIL empty_hold: idx=%0d, required 108", o_index);
    end
    i_req_ready = 1'b1;
    exp_q.push_back('{1'b1, 6'h00, 2'd0});
    press(0, 0, 1);
    n_checks++;
    if (o_req_valid !== 1'b1 || o_req_draw !== 1'b1 || o_req_card !== 6'h00) begin
      n_fail++; $display("FAIL empty_draw_req: valid=%0b draw=%0b card=%h, required 1 1 00", o_req_valid, o_req_draw, o_req_card);
    end
    tick();
    n_checks++;
    if (o_req_valid !== 1'b0 || o_busy !== 1'b1) begin
      n_fail++; $display("FAIL empty_done: valid=%0b busy=%0b, required 0 1", o_req_valid, o_busy);
    end
    i_req_ready = 1'b0;
    end_turn();
  endtask

  task automatic test_play_backpressure();
    i_hand_num = 7'd10;
    i_enable = 1'b1;
    tick();
    repeat (3) press(0, 1, 0);
    n_checks++;
    if (o_index !== 7'd3) begin
      n_fail++; $display("FAIL play_cursor: idx=%0d, required 3", o_index);
    end
    i_card = 6'b100101;
    i_playable = 1'b1;
    exp_q.push_back('{1'b0, 6'h25, 2'b10});
    press(0, 0, 1);
    i_card = 6'h3F;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (o_req_valid !== 1'b1 || o_req_draw !== 1'b0 || o_req_card !== 6'h25 || o_color !== 2'b10) begin
        n_fail++; $display("FAIL play_hold_%0d: valid=%0b draw=%0b card=%h color=%0d, required 1 0 25 2",
                           i, o_req_valid, o_req_draw, o_req_card, o_color);
      end
      press(1, 1, 1);
    end
    i_enable = 1'b0;
    tick();
    n_checks++;
    if (o_req_valid !== 1'b1) begin
      n_fail++; $display("FAIL play_no_withdraw: valid=%0b, required 1", o_req_valid);
    end
    i_enable = 1'b1;
    i_req_ready = 1'b1;
    tick();
    i_req_ready = 1'b0;
    n_checks++;
    if (o_req_valid !== 1'b0 || o_busy !== 1'b1) begin
      n_fail++; $display("FAIL play_done: valid=%0b busy=%0b, required 0 1", o_req_valid, o_busy);
    end
    repeat (3) tick();
    n_checks++;
    if (o_busy !== 1'b1 || o_req_valid !== 1'b0) begin
      n_fail++; $display("FAIL play_done_hold: busy=%0b valid=%0b, required 1 0", o_busy, o_req_valid);
    end
    end_turn();
    n_checks++;
    if (o_busy !== 1'b0) begin
      n_fail++; $display("FAIL play_idle: busy=%0b, required 0", o_busy);
    end
  endtask

  task automatic test_wild();
    i_hand_num = 7'd10;
    i_enable = 1'b1;
    tick();
    i_card = 6'b001110;
    i_playable = 1'b1;
    press(0, 0, 1);
    n_checks++;
    if (o_select_color !== 1'b1 || o_color !== 2'd0 || o_req_valid !== 1'b0) begin
      n_fail++; $display("FAIL wild_enter: sel=%0b color=%0d valid=%0b, required 1 0 0", o_select_color, o_color, o_req_valid);
    end
    press(1, 0, 0);
    n_checks++;
    if (o_color !== 2'd3) begin
      n_fail++; $display("FAIL wild_left: color=%0d, required 3", o_color);
    end
    press(0, 1, 0);
    press(0, 1, 0);
    n_checks++;
    if (o_color !== 2'd1) begin
      n_fail++; $display("FAIL wild_right: color=%0d, required 1", o_color);
    end
    i_req_ready = 1'b1;
    exp_q.push_back('{1'b0, 6'h0E, 2'd1});
    press(0, 0, 1);
    n_checks++;
    if (o_req_valid !== 1'b1 || o_req_card !== 6'h0E || o_color !== 2'd1 || o_select_color !== 1'b0) begin
      n_fail++; $display("FAIL wild_req: valid=%0b card=%h color=%0d sel=%0b, required 1 0e 1 0",
                         o_req_valid, o_req_card, o_color, o_select_color);
    end
    tick();
    i_req_ready = 1'b0;
    end_turn();
  endtask

  task automatic test_reject_abort();
    i_hand_num = 7'd10;
    i_enable = 1'b1;
    tick();
    press(0, 1, 0);
    i_card = 6'h25;
    i_playable = 1'b0;
    i_req_ready = 1'b1;
    press(0, 0, 1);
    n_checks++;
    if (o_reject !== 1'b1 || o_busy !== 1'b1 || o_req_valid !== 1'b0 || o_index !== 7'd1) begin
      n_fail++; $display("FAIL reject_pulse: rej=%0b busy=%0b valid=%0b idx=%0d, required 1 1 0 1",
                         o_reject, o_busy, o_req_valid, o_index);
    end
    tick();
    n_checks++;
    if (o_reject !== 1'b0 || o_req_valid !== 1'b0) begin
      n_fail++; $display("FAIL reject_one_cycle: rej=%0b valid=%0b, required 0 0", o_reject, o_req_valid);
    end
    i_card = 6'h0D;
    i_playable = 1'b1;
    press(0, 0, 1);
    i_enable = 1'b0;
    tick();
    n_checks++;
    if (o_busy !== 1'b0 || o_select_color !== 1'b0 || o_req_valid !== 1'b0) begin
      n_fail++; $display("FAIL color_abort: busy=%0b sel=%0b valid=%0b, required 0 0 0", o_busy, o_select_color, o_req_valid);
    end
    i_req_ready = 1'b0;
    tick();
  endtask

  task automatic test_clamp();
    i_hand_num = 7'd10;
    i_enable = 1'b1;
    tick();
    repeat (9) press(0, 1, 0);
    i_hand_num = 7'd5;
    press(0, 1, 0);
    n_checks++;
    if (o_index !== 7'd4) begin
      n_fail++; $display("FAIL clamp_shrink: idx=%0d, required 4", o_index);
    end
    press(0, 1, 0);
    n_checks++;
    if (o_index !== 7'd108) begin
      n_fail++; $display("FAIL clamp_then_right: idx=%0d, required 108", o_index);
    end
    press(1, 0, 0);
    i_hand_num = 7'd0;
    press(0, 0, 1);
    n_checks++;
    if (o_index !== 7'd108 || o_req_valid !== 1'b0) begin
      n_fail++; $display("FAIL clamp_empty: idx=%0d valid=%0b, required 108 0", o_index, o_req_valid);
    end
    end_turn();
  endtask

`ifdef UNO_CURSOR_TIMEOUT_EN
  task automatic test_timeout();
    i_hand_num = 7'd10;
    i_enable = 1'b1;
    i_req_ready = 1'b0;
    tick();
    repeat (15) tick();
    n_checks++;
    if (o_req_valid !== 1'b0) begin
      n_fail++; $display("FAIL timeout_early: valid=%0b, required 0", o_req_valid);
    end
    exp_q.push_back('{1'b1, 6'h00, 2'd0});
    tick();
    n_checks++;
    if (o_req_valid !== 1'b1 || o_req_draw !== 1'b1) begin
      n_fail++; $display("FAIL timeout_draw: valid=%0b draw=%0b, required 1 1", o_req_valid, o_req_draw);
    end
    i_req_ready = 1'b1;
    tick();
    i_req_ready = 1'b0;
    end_turn();
  endtask
`endif

  initial begin
    test_reset();
    test_nav_wrap();
    test_empty_hand();
    test_play_backpressure();
    test_wild();
    test_reject_abort();
    test_clamp();
`ifdef UNO_CURSOR_TIMEOUT_EN
    test_timeout();
`endif
    repeat (3) tick();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL sb_drain: %0d requests outstanding, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
